ball_motion: RTL and testbench

//  Ball physics engine for Breakout: owns ball position and direction, steps once per frame,
//  and consumes the collision results produced by the collision-detection logic.

---
 rtl/ball_motion.sv | 186 ++++++++++++++++++
 tb/tb_ball_motion.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Breakout ball physics: per-frame stepping, wall/paddle/brick reflection, loss detection.
// Optional BALL_SPEEDUP_EN: step grows by 1 every 8 acked brick hits, saturating at 6.
module ball_motion #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int START_X   = 316,
  parameter int START_Y   = 400,
  parameter int SPEED     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic       hit_paddle,
  input  logic       hit_brick,
  input  logic       hit_horiz,
  output logic       hit_ack,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_dx_neg,
  output logic       ball_dy_neg,
  output logic       ball_lost,
  output logic       ball_active
);

  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_LOST = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  X_RST  = 10'(START_X);
  localparam logic [9:0]  Y_RST  = 10'(START_Y);
  localparam logic [2:0]  STEP0  = 3'(SPEED);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    CHECK,
    LOST
  } state_t;

  state_t state_q, state_d;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dx_neg_q, dx_neg_d;
  logic       dy_neg_q, dy_neg_d;
  logic       hit_ack_q, hit_ack_d;
  logic [2:0] step;

  logic [10:0] x_ext, y_ext, step_ext;
  logic [10:0] x_step, y_step;
  logic        wall_x0, wall_xmax, wall_y0, off_bottom;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] step_q, step_d;
  logic [2:0] brick_cnt_q, brick_cnt_d;

  assign step = step_q;

  always_comb begin
    step_d      = step_q;
    brick_cnt_d = brick_cnt_q;
    if (state_q == CHECK && hit_brick) begin
      brick_cnt_d = brick_cnt_q + 3'd1;
      if (brick_cnt_q == 3'd7 && step_q < 3'd6)
        step_d = step_q + 3'd1;
    end else if (state_q == LOST) begin
      step_d      = STEP0;
      brick_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q      <= STEP0;
      brick_cnt_q <= 3'd0;
    end else begin
      step_q      <= step_d;
      brick_cnt_q <= brick_cnt_d;
    end
  end
`else
  assign step = STEP0;
`endif

  // 11-bit stepping so underflow and overshoot clamp cleanly
  always_comb begin
    x_ext    = {1'b0, x_q};
    y_ext    = {1'b0, y_q};
    step_ext = {8'd0, step};
    x_step   = x_ext + step_ext;
    y_step   = y_ext + step_ext;
    if (dx_neg_q)
      x_step = (x_ext < step_ext) ? 11'd0 : x_ext - step_ext;
    else if (x_step > X_MAX)
      x_step = X_MAX;
    if (dy_neg_q)
      y_step = (y_ext < step_ext) ? 11'd0 : y_ext - step_ext;
  end

  assign wall_x0    = ({1'b0, x_q} == 11'd0);
  assign wall_xmax  = ({1'b0, x_q} == X_MAX);
  assign wall_y0    = ({1'b0, y_q} == 11'd0);
  assign off_bottom = ({1'b0, y_q} >= Y_LOST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (launch) state_d = MOVE;
      MOVE:  if (frame_tick) state_d = CHECK;
      CHECK: state_d = off_bottom ? LOST : MOVE;
      LOST:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    hit_ack_d = 1'b0;
    unique case (state_q)
      MOVE: begin
        if (frame_tick) begin
          x_d = x_step[9:0];
          y_d = y_step[9:0];
        end
      end
      CHECK: begin
        hit_ack_d = hit_paddle | hit_brick;
        // Absolute sets from walls/paddle win over brick toggles
        if (wall_x0)
          dx_neg_d = 1'b0;
        else if (wall_xmax)
          dx_neg_d = 1'b1;
        else if (hit_brick && hit_horiz)
          dx_neg_d = ~dx_neg_q;
        if (wall_y0)
          dy_neg_d = 1'b0;
        if (hit_paddle)
          dy_neg_d = 1'b1;
        if (hit_brick && !hit_horiz && !wall_y0 && !hit_paddle)
          dy_neg_d = ~dy_neg_q;
      end
      LOST: begin
        x_d      = X_RST;
        y_d      = Y_RST;
        dx_neg_d = 1'b0;
        dy_neg_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= X_RST;
      y_q       <= Y_RST;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b1;
      hit_ack_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      hit_ack_q <= hit_ack_d;
    end
  end

  always_comb begin
    ball_x      = x_q;
    ball_y      = y_q;
    ball_dx_neg = dx_neg_q;
    ball_dy_neg = dy_neg_q;
    hit_ack     = hit_ack_q;
    ball_lost   = (state_q == LOST);
    ball_active = (state_q == MOVE) || (state_q == CHECK);
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: reset, stepping, walls, brick/paddle handshake,
// loss and reset during CHECK.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       launch;
  logic       hit_paddle;
  logic       hit_brick;
  logic       hit_horiz;
  logic       hit_ack;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_dx_neg;
  logic       ball_dy_neg;
  logic       ball_lost;
  logic       ball_active;

  int checks = 0;
  int errors = 0;

  ball_motion dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .launch      (launch),
    .hit_paddle  (hit_paddle),
    .hit_brick   (hit_brick),
    .hit_horiz   (hit_horiz),
    .hit_ack     (hit_ack),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_dx_neg (ball_dx_neg),
    .ball_dy_neg (ball_dy_neg),
    .ball_lost   (ball_lost),
    .ball_active (ball_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tick pulse, then return at the negedge after the CHECK cycle
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    launch     = 1'b0;
    hit_paddle = 1'b0;
    hit_brick  = 1'b0;
    hit_horiz  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_x", ball_x, 316);
    chk("rst_y", ball_y, 400);
    chk("rst_dx", ball_dx_neg, 0);
    chk("rst_dy", ball_dy_neg, 1);
    chk("rst_ack", hit_ack, 0);
    chk("rst_lost", ball_lost, 0);
    chk("rst_active", ball_active, 0);

    tick();
    chk("idle_hold_x", ball_x, 316);
    chk("idle_hold_y", ball_y, 400);

    @(negedge clk) launch = 1'b1;
    @(negedge clk) launch = 1'b0;
    chk("launch_active", ball_active, 1);

    repeat (3) tick();
    chk("run3_x", ball_x, 322);
    chk("run3_y", ball_y, 394);
    chk("run3_active", ball_active, 1);

    hit_brick = 1'b1;
    hit_horiz = 1'b0;
    tick();
    chk("bv_y", ball_y, 392);
    chk("bv_dy", ball_dy_neg, 0);
    chk("bv_ack", hit_ack, 1);
    hit_brick = 1'b0;
    @(negedge clk);
    chk("bv_ack_drop", hit_ack, 0);
    chk("bv_dy_hold", ball_dy_neg, 0);
    tick();
    chk("bv_next_y", ball_y, 394);
    chk("bv_next_dy", ball_dy_neg, 0);
    chk("bv_next_ack", hit_ack, 0);

    hit_brick = 1'b1;
    hit_horiz = 1'b1;
    tick();
    chk("bh_x", ball_x, 328);
    chk("bh_dx", ball_dx_neg, 1);
    chk("bh_dy", ball_dy_neg, 0);
    chk("bh_ack", hit_ack, 1);
    hit_brick = 1'b0;
    hit_horiz = 1'b0;

    hit_paddle = 1'b1;
    tick();
    chk("pad_x", ball_x, 326);
    chk("pad_y", ball_y, 398);
    chk("pad_dy", ball_dy_neg, 1);
    chk("pad_ack", hit_ack, 1);
    hit_paddle = 1'b0;

    repeat (162) tick();
    chk("lw_pre_x", ball_x, 2);
    chk("lw_pre_dx", ball_dx_neg, 1);
    tick();
    chk("lw_x", ball_x, 0);
    chk("lw_y", ball_y, 72);
    chk("lw_dx", ball_dx_neg, 0);
    chk("lw_ack", hit_ack, 0);

    repeat (35) tick();
    chk("top_pre_y", ball_y, 2);
    chk("top_pre_dy", ball_dy_neg, 1);
    tick();
    chk("top_y", ball_y, 0);
    chk("top_x", ball_x, 72);
    chk("top_dy", ball_dy_neg, 0);

    repeat (235) tick();
    chk("bot_pre_y", ball_y, 470);
    chk("bot_pre_x", ball_x, 542);
    chk("bot_pre_lost", ball_lost, 0);

    hit_paddle = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("bot_y", ball_y, 472);
    @(negedge clk);
    chk("lost_pulse", ball_lost, 1);
    chk("lost_ack", hit_ack, 1);
    hit_paddle = 1'b0;
    @(negedge clk);
    chk("lost_done", ball_lost, 0);
    chk("lost_x", ball_x, 316);
    chk("lost_y", ball_y, 400);
    chk("lost_dx", ball_dx_neg, 0);
    chk("lost_dy", ball_dy_neg, 1);
    chk("lost_active", ball_active, 0);
    tick();
    chk("lost_idle_x", ball_x, 316);
    chk("lost_idle_y", ball_y, 400);

    @(negedge clk) launch = 1'b1;
    @(negedge clk) launch = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("rc_pre_x", ball_x, 318);
    hit_paddle = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("rc_x", ball_x, 316);
    chk("rc_ack", hit_ack, 0);
    chk("rc_active", ball_active, 0);
    @(negedge clk);
    chk("rc_ack2", hit_ack, 0);
    reset_n    = 1'b1;
    hit_paddle = 1'b0;
    @(negedge clk);
    chk("rc_post_ack", hit_ack, 0);
    chk("rc_post_y", ball_y, 400);
    chk("rc_post_dy", ball_dy_neg, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
